// File: rtl/key_pkg.sv
// Shared definitions for the key load controller and the key RAM instantiation.
package key_pkg;

  // Default key geometry; the key RAM must be instantiated with the same values.
  localparam int unsigned KeyWords          = 4;
  localparam int unsigned KeyWordSize       = 32;
  localparam int unsigned KeyTimeoutCycles  = 1024;

  // Load sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCommit,
    StReady,
    StZero
  } key_state_e;

endpackage

// File: rtl/key_word_cnt.sv
// Key word index counter: synchronous clear (wins over increment), increment and
// last-word flag. WORDS must be at least 2.
module key_word_cnt
  import key_pkg::*;
#(
  parameter int unsigned WORDS = KeyWords
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     inc_i,
  output logic [$clog2(WORDS)-1:0] cnt_o,
  output logic                     last_o
);

  localparam int unsigned CntW = $clog2(WORDS);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next index: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CntW'(WORDS - 1));

endmodule

// File: rtl/key_load_ctrl.sv
// Key load controller: writes a multi-word key from a valid/ready stream into the
// key RAM, tracks key validity, strobes key_update to the AES core and zeroizes
// the stored key on request.
// Optional build macro KEY_LOAD_TIMEOUT_EN: abort a stalled LOAD into zeroization
// after TIMEOUT_CYCLES idle (non-busy) cycles without a handshake.
module key_load_ctrl
  import key_pkg::*;
#(
  parameter int unsigned WORDS          = KeyWords,
  parameter int unsigned WORD_SIZE      = KeyWordSize,
  parameter int unsigned TIMEOUT_CYCLES = KeyTimeoutCycles
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     zeroize,
  input  logic                     aes_busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_SIZE-1:0]     in_data,
  output logic [$clog2(WORDS)-1:0] ram_widx,
  output logic                     ram_wen,
  output logic [WORD_SIZE-1:0]     ram_wdata,
  output logic                     key_valid,
  output logic                     key_update,
  output logic                     load_err,
  output logic                     busy
);

  key_state_e state_q, state_d;
  logic       key_valid_q, key_valid_d;
  logic       key_update_q, key_update_d;
  logic       load_err_q, load_err_d;

  logic                     cnt_clr, cnt_inc, cnt_last;
  logic [$clog2(WORDS)-1:0] cnt;
  logic                     stream_hs;
  logic                     load_wr;
  logic                     timeout;

  key_word_cnt #(
    .WORDS (WORDS)
  ) u_word_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  assign stream_hs = (state_q == StLoad) && in_valid && !aes_busy;
  // A word arriving alongside load_start or zeroize is dropped, not written.
  assign load_wr   = stream_hs && !load_start && !zeroize;

`ifdef KEY_LOAD_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;

  // Idle counter: cleared outside LOAD, on handshakes and on load_start; frozen by aes_busy.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_q != StLoad || stream_hs || load_start) begin
      idle_cnt_d = '0;
    end else if (!aes_busy) begin
      idle_cnt_d = idle_cnt_q + IdleW'(1);
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign timeout = (state_q == StLoad) && !stream_hs && !aes_busy && !load_start &&
                   (idle_cnt_q == IdleW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout               = 1'b0;
`endif

  // Next-state, counter control and registered-output decode; zeroize outranks everything.
  always_comb begin
    state_d      = state_q;
    key_valid_d  = key_valid_q;
    key_update_d = 1'b0;
    load_err_d   = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;

    if (zeroize) begin
      state_d     = StZero;
      key_valid_d = 1'b0;
      cnt_clr     = 1'b1;
      load_err_d  = (state_q == StLoad);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_start) begin
            state_d = StLoad;
            cnt_clr = 1'b1;
          end
        end
        StLoad: begin
          if (load_start) begin
            cnt_clr    = 1'b1;
            load_err_d = 1'b1;
          end else if (stream_hs) begin
            cnt_inc = 1'b1;
            if (cnt_last) begin
              state_d      = StCommit;
              cnt_clr      = 1'b1;
              key_update_d = 1'b1;
            end
          end else if (timeout) begin
            state_d    = StZero;
            cnt_clr    = 1'b1;
            load_err_d = 1'b1;
          end
        end
        StCommit: begin
          state_d     = StReady;
          key_valid_d = 1'b1;
        end
        StReady: begin
          if (load_start) begin
            state_d     = StLoad;
            key_valid_d = 1'b0;
            cnt_clr     = 1'b1;
          end
        end
        StZero: begin
          cnt_inc = 1'b1;
          if (cnt_last) begin
            state_d = StIdle;
            cnt_clr = 1'b1;
          end
        end
        default: begin
          state_d     = StIdle;
          key_valid_d = 1'b0;
          cnt_clr     = 1'b1;
        end
      endcase
    end
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      key_valid_q  <= 1'b0;
      key_update_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_valid_q  <= key_valid_d;
      key_update_q <= key_update_d;
      load_err_q   <= load_err_d;
    end
  end

  // Stream acceptance and key RAM write port; zeroization writes ignore aes_busy.
  always_comb begin
    in_ready  = (state_q == StLoad) && !aes_busy;
    ram_wen   = load_wr || (state_q == StZero);
    ram_widx  = cnt;
    ram_wdata = load_wr ? in_data : '0;
  end

  assign key_valid  = key_valid_q;
  assign key_update = key_update_q;
  assign load_err   = load_err_q;
  assign busy       = (state_q == StLoad) || (state_q == StCommit) || (state_q == StZero);

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl. Inputs change on the falling edge and outputs
// are sampled 1 ns later, well before the next rising edge.
module tb_key_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, zeroize, aes_busy, in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  ram_widx;
  logic        ram_wen;
  logic [31:0] ram_wdata;
  logic        key_valid, key_update, load_err, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_load_ctrl #(
    .WORDS          (4),
    .WORD_SIZE      (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .zeroize    (zeroize),
    .aes_busy   (aes_busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .ram_widx   (ram_widx),
    .ram_wen    (ram_wen),
    .ram_wdata  (ram_wdata),
    .key_valid  (key_valid),
    .key_update (key_update),
    .load_err   (load_err),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one word at the current falling edge and check the combinational write.
  task automatic send_word(input logic [31:0] d, input int idx, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    check_eq({tag, "_wen"}, 32'(ram_wen), 32'd1);
    check_eq({tag, "_widx"}, 32'(ram_widx), 32'(idx));
    check_eq({tag, "_wdata"}, ram_wdata, d);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Expect a full zeroization sequence starting now; load_start is pulsed mid-way.
  task automatic zero_seq(input string tag);
    for (int i = 0; i < 4; i++) begin
      load_start = (i == 1);
      #1;
      check_eq({tag, "_zwen"}, 32'(ram_wen), 32'd1);
      check_eq({tag, "_zwidx"}, 32'(ram_widx), 32'(i));
      check_eq({tag, "_zwdata"}, ram_wdata, 32'd0);
      check_eq({tag, "_zkv"}, 32'(key_valid), 32'd0);
      check_eq({tag, "_zupd"}, 32'(key_update), 32'd0);
      check_eq({tag, "_zrdy"}, 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    load_start = 1'b0;
    #1;
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_idle_wen"}, 32'(ram_wen), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    zeroize    = 1'b0;
    aes_busy   = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_kv", 32'(key_valid), 32'd0);
    check_eq("rst_upd", 32'(key_update), 32'd0);
    check_eq("rst_err", 32'(load_err), 32'd0);
    check_eq("rst_rdy", 32'(in_ready), 32'd0);
    check_eq("rst_wen", 32'(ram_wen), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: plain four-word load
    load_start = 1'b1;
    in_valid   = 1'b1;
    #1;
    check_eq("t1_idle_rdy", 32'(in_ready), 32'd0);
    check_eq("t1_idle_wen", 32'(ram_wen), 32'd0);
    @(negedge clk);
    load_start = 1'b0;
    send_word(32'h1111_1111, 0, "t1w0");
    send_word(32'h2222_2222, 1, "t1w1");
    send_word(32'h3333_3333, 2, "t1w2");
    send_word(32'h4444_4444, 3, "t1w3");
    #1;
    check_eq("t1_upd", 32'(key_update), 32'd1);
    check_eq("t1_kv_commit", 32'(key_valid), 32'd0);
    check_eq("t1_err", 32'(load_err), 32'd0);
    check_eq("t1_busy_commit", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check_eq("t1_upd_off", 32'(key_update), 32'd0);
    check_eq("t1_kv", 32'(key_valid), 32'd1);
    check_eq("t1_busy_ready", 32'(busy), 32'd0);

    // 2: aes_busy stalls word 2 for five cycles
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    #1;
    check_eq("t2_kv_clr", 32'(key_valid), 32'd0);
    check_eq("t2_rdy", 32'(in_ready), 32'd1);
    send_word(32'hA0A0_A0A0, 0, "t2w0");
    send_word(32'hA1A1_A1A1, 1, "t2w1");
    aes_busy = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hA2A2_A2A2;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("t2_stall_rdy", 32'(in_ready), 32'd0);
      check_eq("t2_stall_wen", 32'(ram_wen), 32'd0);
      @(negedge clk);
    end
    aes_busy = 1'b0;
    send_word(32'hA2A2_A2A2, 2, "t2w2");
    send_word(32'hA3A3_A3A3, 3, "t2w3");
    #1;
    check_eq("t2_upd", 32'(key_update), 32'd1);
    @(negedge clk);
    #1;
    check_eq("t2_kv", 32'(key_valid), 32'd1);

    // 3: restart after two words
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    send_word(32'hB0B0_B0B0, 0, "t3w0");
    send_word(32'hB1B1_B1B1, 1, "t3w1");
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = 32'hBADB_AD00;
    #1;
    check_eq("t3_restart_wen", 32'(ram_wen), 32'd0);
    check_eq("t3_restart_err", 32'(load_err), 32'd0);
    @(negedge clk);
    load_start = 1'b0;
    in_valid   = 1'b0;
    #1;
    check_eq("t3_err", 32'(load_err), 32'd1);
    send_word(32'hC0C0_C0C0, 0, "t3w0b");
    #1;
    check_eq("t3_err_off", 32'(load_err), 32'd0);
    send_word(32'hC1C1_C1C1, 1, "t3w1b");
    send_word(32'hC2C2_C2C2, 2, "t3w2b");
    send_word(32'hC3C3_C3C3, 3, "t3w3b");
    #1;
    check_eq("t3_upd", 32'(key_update), 32'd1);
    check_eq("t3_upd_err", 32'(load_err), 32'd0);
    @(negedge clk);
    #1;
    check_eq("t3_upd_once", 32'(key_update), 32'd0);
    check_eq("t3_kv", 32'(key_valid), 32'd1);

    // 4: zeroize from READY, with aes_busy high and junk on in_data
    zeroize = 1'b1;
    #1;
    check_eq("t4_ready_wen", 32'(ram_wen), 32'd0);
    @(negedge clk);
    zeroize  = 1'b0;
    aes_busy = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    #1;
    check_eq("t4_busy", 32'(busy), 32'd1);
    check_eq("t4_err", 32'(load_err), 32'd0);
    zero_seq("t4");
    aes_busy = 1'b0;
    in_data  = '0;
    check_eq("t4_kv_end", 32'(key_valid), 32'd0);

    // 5: zeroize and load_start together during LOAD
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    send_word(32'hD0D0_D0D0, 0, "t5w0");
    zeroize    = 1'b1;
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = 32'hDEAD_BEEF;
    #1;
    check_eq("t5_wen", 32'(ram_wen), 32'd0);
    @(negedge clk);
    zeroize    = 1'b0;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    #1;
    check_eq("t5_err", 32'(load_err), 32'd1);
    zero_seq("t5");
    check_eq("t5_err_off", 32'(load_err), 32'd0);
    check_eq("t5_kv", 32'(key_valid), 32'd0);

    // 6: stall in LOAD with no words
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    send_word(32'hE0E0_E0E0, 0, "t6w0");
`ifdef KEY_LOAD_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("t6_wait_err", 32'(load_err), 32'd0);
      check_eq("t6_wait_rdy", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    #1;
    check_eq("t6_to_err", 32'(load_err), 32'd1);
    zero_seq("t6");
    check_eq("t6_kv", 32'(key_valid), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      #1;
      check_eq("t6_wait_err", 32'(load_err), 32'd0);
      check_eq("t6_wait_rdy", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    send_word(32'hE1E1_E1E1, 1, "t6w1");
    send_word(32'hE2E2_E2E2, 2, "t6w2");
    send_word(32'hE3E3_E3E3, 3, "t6w3");
    #1;
    check_eq("t6_upd", 32'(key_update), 32'd1);
    @(negedge clk);
`endif

    // 7: asynchronous reset in the middle of a load
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    send_word(32'hF0F0_F0F0, 0, "t7w0");
    rst = 1'b1;
    #1;
    check_eq("t7_busy", 32'(busy), 32'd0);
    check_eq("t7_rdy", 32'(in_ready), 32'd0);
    check_eq("t7_kv", 32'(key_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_load_ctrl.md
Name: key_load_ctrl

Overview:
- Sequences loading of a multi-word cipher key into the key RAM from a 32-bit valid/ready word stream.
- Tracks key validity and pulses a key-update strobe to the AES core once all words are written.
- Provides zeroization of the stored key.
- Sits between the bus-side key register interface and the key RAM / AES core.

Parameters:
- WORDS, 4, number of key words; must match the key RAM.
- WORD_SIZE, 32, bits per key word.
- TIMEOUT_CYCLES, 1024, idle-cycle limit in LOAD; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- load_start  in  1  pulse; begin a new key load, discarding any partial load.
- zeroize  in  1  pulse; erase the stored key.
- aes_busy  in  1  AES core is using the key; stalls loading.
- in_valid  in  1  key word valid.
- in_ready  out  1  key word accepted when in_valid & in_ready.
- in_data  in  WORD_SIZE  key word; word 0 first.
- ram_widx  out  $clog2(WORDS)  key RAM write index.
- ram_wen  out  1  key RAM write enable.
- ram_wdata  out  WORD_SIZE  key RAM write data.
- key_valid  out  1  full key present in the RAM.
- key_update  out  1  one-cycle pulse; AES core must re-expand the key.
- load_err  out  1  one-cycle pulse; load aborted.
- busy  out  1  state is LOAD, COMMIT or ZERO.

Behaviour:
- Reset (async): state=IDLE, cnt=0, key_valid=0, key_update=0, load_err=0.
- States: IDLE, LOAD, COMMIT, READY, ZERO. Registered state; registered cnt of width $clog2(WORDS).
- Priority each cycle: zeroize > load_start > stream handshake.
- IDLE:
  - load_start -> LOAD, cnt<=0.
- LOAD:
  - in_ready = !aes_busy.
  - On handshake (same cycle, combinational): ram_wen=1, ram_widx=cnt, ram_wdata=in_data.
  - Handshake with cnt<WORDS-1: cnt increments.
  - Handshake with cnt==WORDS-1: -> COMMIT, cnt<=0.
  - load_start while in LOAD: cnt<=0, load_err pulses next cycle, stays in LOAD. A handshake in the same cycle is ignored (ram_wen=0).
- COMMIT (1 cycle):
  - key_update=1, key_valid<=1, -> READY.
  - key_update is asserted in the cycle after the final handshake.
- READY:
  - key_valid=1.
  - load_start -> LOAD; key_valid<=0 on the same edge.
- ZERO (entered from any state on zeroize):
  - key_valid<=0, cnt<=0.
  - Each cycle: ram_wen=1, ram_widx=cnt, ram_wdata=0; ignores aes_busy.
  - Completes in exactly WORDS cycles, then -> IDLE.
  - zeroize re-asserted in ZERO restarts at cnt=0.
  - load_start in ZERO is ignored.
  - Zeroize entered from LOAD pulses load_err.
- Output defaults:
  - in_ready=0 outside LOAD.
  - ram_wen=0 outside LOAD handshakes and ZERO.
  - ram_wdata=0 when ram_wen=0.
- key_update and load_err are never asserted in the same cycle.
- aes_busy held high stalls LOAD indefinitely; no partial key is ever flagged valid.
- rst asserted mid-LOAD or mid-ZERO: immediate return to IDLE. The RAM is reset separately.

Optional Feature:
- Macro: KEY_LOAD_TIMEOUT_EN.
- With the macro defined:
  - An idle counter runs in LOAD; it resets on every handshake and on load_start.
  - Reaching TIMEOUT_CYCLES with no handshake -> ZERO; load_err pulses.
  - The counter does not advance while aes_busy=1.
- Without the macro: no counter logic, LOAD waits indefinitely, and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package key_pkg:
  - State enum typedef (IDLE, LOAD, COMMIT, READY, ZERO).
  - Default WORDS/WORD_SIZE constants shared with the key RAM instantiation.
- Sub-module: the word index counter, key_word_cnt (clear, increment, last-word flag). The FSM stays in the top module.

Test Plan:
1. Reset, load_start, words 0x11111111..0x44444444 with aes_busy=0 -> ram_wen on 4 consecutive cycles with widx 0..3; key_update pulses 1 cycle after the 4th word; key_valid=1.
2. aes_busy=1 during word 2 for 5 cycles -> in_ready=0 and no writes for those 5 cycles; load completes with correct data order.
3. load_start after 2 words -> load_err pulse, cnt restarts at 0; the next 4 words write widx 0..3; key_update pulses once.
4. zeroize from READY -> key_valid=0 next cycle; 4 writes of 0 to widx 0..3; IDLE after 4 cycles; no key_update.
5. zeroize and load_start in the same cycle during LOAD -> ZERO taken, load_err pulses, and no stream word is written.
6. With KEY_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=8: 1 word, then in_valid=0 for 8 cycles -> load_err, ZERO sequence, IDLE, key_valid=0.
